// File: rtl/mux_rr_arbiter.sv
// Round-robin select controller for a shared N:1 mux channel.
// Grants are held for up to MAX_HOLD accepted transfers, then a one-cycle idle gap.
module mux_rr_arbiter #(
  parameter int N        = 4,
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            req,
  input  logic [N*W-1:0]          data_in,
  input  logic                    ready,
  output logic [N-1:0]            grant,
  output logic [$clog2(N)-1:0]    sel,
  output logic                    valid,
  output logic [W-1:0]            s,
  output logic                    busy
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [SW-1:0]   r_sel;
  logic            r_busy;
  logic [SW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;

  state_t          w_state_next;
  logic [N-1:0]    w_grant_next;
  logic [SW-1:0]   w_sel_next;
  logic            w_busy_next;
  logic [SW-1:0]   w_ptr_next;
  logic [CW-1:0]   w_cnt_next;

  logic [SW-1:0]   w_winner;
  logic [SW-1:0]   w_idx;
  logic            w_valid;
  logic            w_xfer;
  logic            w_last_beat;
  logic [W-1:0]    w_slot [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign w_slot[gi] = data_in[gi*W +: W];
    end
  endgenerate

  // Descending scan so the lowest offset from r_ptr is the last (winning) assignment.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = r_ptr + SW'(k);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_valid     = r_busy & req[r_sel];
  assign w_xfer      = w_valid & ready;
  assign w_last_beat = w_xfer && (r_cnt == CW'(MAX_HOLD - 1));

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_sel_next   = r_sel;
    w_busy_next  = r_busy;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_next = S_GRANT;
          w_sel_next   = w_winner;
          w_grant_next = N'(1) << w_winner;
          w_busy_next  = 1'b1;
          w_cnt_next   = '0;
        end
      end
      S_GRANT: begin
        // Release wins over a final-beat count update; owner drops to lowest priority.
        if (!req[r_sel] || w_last_beat) begin
          w_state_next = S_IDLE;
          w_grant_next = '0;
          w_busy_next  = 1'b0;
          w_cnt_next   = '0;
          w_ptr_next   = r_sel + SW'(1);
        end else if (w_xfer) begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_sel   <= w_sel_next;
      r_busy  <= w_busy_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;
  assign valid = w_valid;
  assign s     = w_valid ? w_slot[r_sel] : '0;

endmodule
